// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, stage-control bundles and hazard helpers for the MIPS32 pipeline control unit.
package pipeline_ctrl_pkg;

   localparam int NREG_BITS = 5;
   localparam int ALUCTRL_W = 11;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_COP0  = 6'h10;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ERET = 6'h18;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   localparam logic [4:0] C0_MF = 5'h00;
   localparam logic [4:0] C0_MT = 5'h04;
   localparam logic [4:0] C0_CO = 5'h10;

   // One-hot ALU operations; lui reuses the shift-left slot on the immediate.
   localparam logic [ALUCTRL_W-1:0] ALU_ADD  = 11'h001;
   localparam logic [ALUCTRL_W-1:0] ALU_SUB  = 11'h002;
   localparam logic [ALUCTRL_W-1:0] ALU_AND  = 11'h004;
   localparam logic [ALUCTRL_W-1:0] ALU_OR   = 11'h008;
   localparam logic [ALUCTRL_W-1:0] ALU_XOR  = 11'h010;
   localparam logic [ALUCTRL_W-1:0] ALU_NOR  = 11'h020;
   localparam logic [ALUCTRL_W-1:0] ALU_SLT  = 11'h040;
   localparam logic [ALUCTRL_W-1:0] ALU_SLTU = 11'h080;
   localparam logic [ALUCTRL_W-1:0] ALU_SLL  = 11'h100;
   localparam logic [ALUCTRL_W-1:0] ALU_SRL  = 11'h200;
   localparam logic [ALUCTRL_W-1:0] ALU_SRA  = 11'h400;

   typedef enum logic [1:0] {
      BYP_REGFILE = 2'b00,
      BYP_EX      = 2'b01,
      BYP_MEM     = 2'b10,
      BYP_WB      = 2'b11
   } bypass_e;

   typedef struct packed {
      logic [ALUCTRL_W-1:0] aluCtrl;
      logic                 mc0;
      logic                 c0we;
      logic                 invalid;
      logic                 memRead;
      logic                 memWrite;
      logic                 memtoReg;
      logic                 regWr;
   } exCtrl_t;

   typedef struct packed {
      logic memRead;
      logic memWrite;
      logic memtoReg;
      logic regWr;
   } memCtrl_t;

   typedef struct packed {
      logic    regDst;
      logic    extOp;
      logic    aluSrc;
      logic    j;
      logic    jr;
      logic    beq;
      logic    bne;
      logic    eret;
      logic    readsRt;
      exCtrl_t ex;
   } decCtrl_t;

   function automatic logic regMatch(input logic                 wr,
                                     input logic [NREG_BITS-1:0] rw,
                                     input logic [NREG_BITS-1:0] src);
      return wr && (rw != '0) && (rw == src);
   endfunction

   function automatic bypass_e fwdSelect(input logic [NREG_BITS-1:0] src,
                                         input logic                 exWr,
                                         input logic [NREG_BITS-1:0] rwEx,
                                         input logic                 memWr,
                                         input logic [NREG_BITS-1:0] rwMem,
                                         input logic                 wbWr,
                                         input logic [NREG_BITS-1:0] rwW);
      if (regMatch(exWr, rwEx, src))   return BYP_EX;
      if (regMatch(memWr, rwMem, src)) return BYP_MEM;
      if (regMatch(wbWr, rwW, src))    return BYP_WB;
      return BYP_REGFILE;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_unit_if.sv
// Control/status bundle between the pipeline control unit (master) and the datapath (slave).
interface pipeline_ctrl_unit_if;
   import pipeline_ctrl_pkg::*;

   logic [31:0]          i_instruction;
   logic [NREG_BITS-1:0] i_rw_d;
   logic [NREG_BITS-1:0] i_rw_ex;
   logic [NREG_BITS-1:0] i_rw_mem;
   logic [NREG_BITS-1:0] i_rw_w;
   logic                 i_overflow;
   logic                 i_interrupt;

   logic                 o_RegDst;
   logic                 o_ExtOp;
   logic                 o_ALUSrc;
   logic                 o_J;
   logic                 o_Jr;
   logic                 o_Beq;
   logic                 o_Bne;
   logic                 o_eret;
   logic [ALUCTRL_W-1:0] o_ALUCtrl;
   logic                 o_mc0;
   logic                 o_coproc0_we;
   logic                 o_coproc0_invalid_instr;
   logic                 o_MemRead;
   logic                 o_MemWrite;
   logic                 o_MemtoReg;
   logic                 o_RegWr;
   logic [1:0]           o_ASrc;
   logic [1:0]           o_BSrc;
   logic                 o_stall;

   modport master (
      input  i_instruction, i_rw_d, i_rw_ex, i_rw_mem, i_rw_w, i_overflow, i_interrupt,
      output o_RegDst, o_ExtOp, o_ALUSrc, o_J, o_Jr, o_Beq, o_Bne, o_eret,
             o_ALUCtrl, o_mc0, o_coproc0_we, o_coproc0_invalid_instr,
             o_MemRead, o_MemWrite, o_MemtoReg, o_RegWr, o_ASrc, o_BSrc, o_stall
   );

   modport slave (
      output i_instruction, i_rw_d, i_rw_ex, i_rw_mem, i_rw_w, i_overflow, i_interrupt,
      input  o_RegDst, o_ExtOp, o_ALUSrc, o_J, o_Jr, o_Beq, o_Bne, o_eret,
             o_ALUCtrl, o_mc0, o_coproc0_we, o_coproc0_invalid_instr,
             o_MemRead, o_MemWrite, o_MemtoReg, o_RegWr, o_ASrc, o_BSrc, o_stall
   );
endinterface

// File: rtl/pipeline_main_decoder.sv
// Combinational MIPS32 decoder: instruction word -> decode-stage controls plus the EX-bound bundle.
module pipeline_main_decoder
   import pipeline_ctrl_pkg::*;
(
   input  logic [31:0] i_instruction,
   output decCtrl_t    o_ctrl
);

   logic [5:0] w_op;
   logic [5:0] w_funct;
   logic [4:0] w_rs;
   logic       w_unusedFields;

   assign w_op           = i_instruction[31:26];
   assign w_rs           = i_instruction[25:21];
   assign w_funct        = i_instruction[5:0];
   assign w_unusedFields = ^i_instruction[20:6];

   // Unknown encodings fall through to invalid with every write enable left at zero.
   always_comb begin
      o_ctrl = '0;
      case (w_op)
         OP_RTYPE: begin
            o_ctrl.regDst   = 1'b1;
            o_ctrl.readsRt  = 1'b1;
            o_ctrl.ex.regWr = 1'b1;
            case (w_funct)
               FN_ADD, FN_ADDU: o_ctrl.ex.aluCtrl = ALU_ADD;
               FN_SUB, FN_SUBU: o_ctrl.ex.aluCtrl = ALU_SUB;
               FN_AND:          o_ctrl.ex.aluCtrl = ALU_AND;
               FN_OR:           o_ctrl.ex.aluCtrl = ALU_OR;
               FN_XOR:          o_ctrl.ex.aluCtrl = ALU_XOR;
               FN_NOR:          o_ctrl.ex.aluCtrl = ALU_NOR;
               FN_SLT:          o_ctrl.ex.aluCtrl = ALU_SLT;
               FN_SLTU:         o_ctrl.ex.aluCtrl = ALU_SLTU;
               FN_SLL:          o_ctrl.ex.aluCtrl = ALU_SLL;
               FN_SRL:          o_ctrl.ex.aluCtrl = ALU_SRL;
               FN_SRA:          o_ctrl.ex.aluCtrl = ALU_SRA;
               FN_JR: begin
                  o_ctrl.jr       = 1'b1;
                  o_ctrl.regDst   = 1'b0;
                  o_ctrl.ex.regWr = 1'b0;
               end
               default: begin
                  o_ctrl.regDst     = 1'b0;
                  o_ctrl.ex.regWr   = 1'b0;
                  o_ctrl.ex.invalid = 1'b1;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            o_ctrl.extOp      = 1'b1;
            o_ctrl.aluSrc     = 1'b1;
            o_ctrl.ex.aluCtrl = ALU_ADD;
            o_ctrl.ex.regWr   = 1'b1;
         end
         OP_SLTI, OP_SLTIU: begin
            o_ctrl.extOp      = 1'b1;
            o_ctrl.aluSrc     = 1'b1;
            o_ctrl.ex.aluCtrl = (w_op == OP_SLTI) ? ALU_SLT : ALU_SLTU;
            o_ctrl.ex.regWr   = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            o_ctrl.aluSrc     = 1'b1;
            o_ctrl.ex.aluCtrl = (w_op == OP_ANDI) ? ALU_AND :
                                (w_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
            o_ctrl.ex.regWr   = 1'b1;
         end
         OP_LUI: begin
            o_ctrl.aluSrc     = 1'b1;
            o_ctrl.ex.aluCtrl = ALU_SLL;
            o_ctrl.ex.regWr   = 1'b1;
         end
         OP_LW: begin
            o_ctrl.extOp       = 1'b1;
            o_ctrl.aluSrc      = 1'b1;
            o_ctrl.ex.aluCtrl  = ALU_ADD;
            o_ctrl.ex.memRead  = 1'b1;
            o_ctrl.ex.memtoReg = 1'b1;
            o_ctrl.ex.regWr    = 1'b1;
         end
         OP_SW: begin
            o_ctrl.extOp       = 1'b1;
            o_ctrl.aluSrc      = 1'b1;
            o_ctrl.readsRt     = 1'b1;
            o_ctrl.ex.aluCtrl  = ALU_ADD;
            o_ctrl.ex.memWrite = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            o_ctrl.extOp      = 1'b1;
            o_ctrl.readsRt    = 1'b1;
            o_ctrl.beq        = (w_op == OP_BEQ);
            o_ctrl.bne        = (w_op == OP_BNE);
            o_ctrl.ex.aluCtrl = ALU_SUB;
         end
         OP_J: o_ctrl.j = 1'b1;
         OP_COP0: begin
            if (w_rs == C0_MF) begin
               o_ctrl.ex.mc0   = 1'b1;
               o_ctrl.ex.regWr = 1'b1;
            end else if (w_rs == C0_MT) begin
               o_ctrl.readsRt = 1'b1;
               o_ctrl.ex.c0we = 1'b1;
            end else if (w_rs == C0_CO && w_funct == FN_ERET) begin
               o_ctrl.eret = 1'b1;
            end else begin
               o_ctrl.ex.invalid = 1'b1;
            end
         end
         default: o_ctrl.ex.invalid = 1'b1;
      endcase
      if (i_instruction == 32'h0000_0000) o_ctrl = '0;
   end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// MIPS32 5-stage pipeline control and hazard unit: decode, EX/MEM/WB control shadows, forwarding, stalls.
// Build option: define PIPELINE_FORWARDING_EN for bypassing with load-use stalls only; otherwise stall on any hazard.
module pipeline_ctrl_unit
   import pipeline_ctrl_pkg::*;
(
   input logic                  i_clk,
   input logic                  i_rst_n,
   pipeline_ctrl_unit_if.master io_bus
);

   decCtrl_t             w_dec;
   exCtrl_t              r_ex;
   memCtrl_t             r_mem;
   logic                 r_wbRegWr;
   memCtrl_t             w_exToMem;
   logic [NREG_BITS-1:0] w_rs;
   logic [NREG_BITS-1:0] w_rt;
   logic                 w_stall;
   logic                 w_bubbleEx;
   logic                 w_squashMem;
   bypass_e              w_aSrc;
   bypass_e              w_bSrc;
   logic                 w_unusedRwD;

   pipeline_main_decoder u_decoder (
      .i_instruction (io_bus.i_instruction),
      .o_ctrl        (w_dec)
   );

   assign w_rs        = io_bus.i_instruction[25:21];
   assign w_rt        = io_bus.i_instruction[20:16];
   assign w_unusedRwD = ^io_bus.i_rw_d;

   assign w_exToMem   = '{memRead:  r_ex.memRead,
                          memWrite: r_ex.memWrite,
                          memtoReg: r_ex.memtoReg,
                          regWr:    r_ex.regWr};
   assign w_bubbleEx  = w_stall | io_bus.i_interrupt | w_dec.eret;
   assign w_squashMem = io_bus.i_overflow | io_bus.i_interrupt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ex      <= '0;
         r_mem     <= '0;
         r_wbRegWr <= 1'b0;
      end else begin
         r_ex      <= w_bubbleEx  ? '0 : w_dec.ex;
         r_mem     <= w_squashMem ? '0 : w_exToMem;
         r_wbRegWr <= r_mem.regWr;
      end
   end

`ifdef PIPELINE_FORWARDING_EN
   // Only a load sitting in EX cannot be bypassed; its data appears one stage later.
   always_comb begin
      w_aSrc  = fwdSelect(w_rs, r_ex.regWr, io_bus.i_rw_ex, r_mem.regWr, io_bus.i_rw_mem,
                          r_wbRegWr, io_bus.i_rw_w);
      w_bSrc  = fwdSelect(w_rt, r_ex.regWr, io_bus.i_rw_ex, r_mem.regWr, io_bus.i_rw_mem,
                          r_wbRegWr, io_bus.i_rw_w);
      w_stall = r_ex.memRead &
                (regMatch(r_ex.regWr, io_bus.i_rw_ex, w_rs) |
                 (w_dec.readsRt & regMatch(r_ex.regWr, io_bus.i_rw_ex, w_rt)));
   end
`else
   // Without bypassing, any in-flight writer of a read source holds decode until it retires.
   always_comb begin
      w_aSrc  = BYP_REGFILE;
      w_bSrc  = BYP_REGFILE;
      w_stall = regMatch(r_ex.regWr, io_bus.i_rw_ex, w_rs) |
                regMatch(r_mem.regWr, io_bus.i_rw_mem, w_rs) |
                regMatch(r_wbRegWr, io_bus.i_rw_w, w_rs) |
                (w_dec.readsRt & (regMatch(r_ex.regWr, io_bus.i_rw_ex, w_rt) |
                                  regMatch(r_mem.regWr, io_bus.i_rw_mem, w_rt) |
                                  regMatch(r_wbRegWr, io_bus.i_rw_w, w_rt)));
   end
`endif

   assign io_bus.o_RegDst                = w_dec.regDst;
   assign io_bus.o_ExtOp                 = w_dec.extOp;
   assign io_bus.o_ALUSrc                = w_dec.aluSrc;
   assign io_bus.o_J                     = w_dec.j;
   assign io_bus.o_Jr                    = w_dec.jr;
   assign io_bus.o_Beq                   = w_dec.beq;
   assign io_bus.o_Bne                   = w_dec.bne;
   assign io_bus.o_eret                  = w_dec.eret;
   assign io_bus.o_ALUCtrl               = r_ex.aluCtrl;
   assign io_bus.o_mc0                   = r_ex.mc0;
   assign io_bus.o_coproc0_we            = r_ex.c0we;
   assign io_bus.o_coproc0_invalid_instr = r_ex.invalid;
   assign io_bus.o_MemRead               = r_mem.memRead;
   assign io_bus.o_MemWrite              = r_mem.memWrite;
   assign io_bus.o_MemtoReg              = r_mem.memtoReg;
   assign io_bus.o_RegWr                 = r_wbRegWr;
   assign io_bus.o_ASrc                  = w_aSrc;
   assign io_bus.o_BSrc                  = w_bSrc;
   assign io_bus.o_stall                 = w_stall;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed self-checking bench for pipeline_ctrl_unit; hazard expectations follow PIPELINE_FORWARDING_EN.
module tb_pipeline_ctrl_unit;

   localparam logic [31:0] I_NOP      = 32'h0000_0000;
   localparam logic [31:0] I_ADD_3_12 = 32'h0022_1820; // add $3,$1,$2
   localparam logic [31:0] I_SUB_4_31 = 32'h0061_2022; // sub $4,$3,$1
   localparam logic [31:0] I_AND_5_33 = 32'h0063_2824; // and $5,$3,$3
   localparam logic [31:0] I_OR_7_34  = 32'h0064_3825; // or  $7,$3,$4
   localparam logic [31:0] I_LW_5     = 32'h8C05_0000; // lw  $5,0($0)
   localparam logic [31:0] I_ADD_6_55 = 32'h00A5_3020; // add $6,$5,$5
   localparam logic [31:0] I_ADD_0_11 = 32'h0021_0020; // add $0,$1,$1
   localparam logic [31:0] I_OR_7_00  = 32'h0000_3825; // or  $7,$0,$0
   localparam logic [31:0] I_BAD      = 32'hFC00_0000; // opcode 0x3F
   localparam logic [31:0] I_MFC0_8   = 32'h4008_6000; // mfc0 $8,$12
   localparam logic [31:0] I_MTC0_9   = 32'h4089_6000; // mtc0 $9,$12
   localparam logic [31:0] I_ERET     = 32'h4200_0018;

   localparam logic [31:0] ALU_ADD_X = 32'h001;
   localparam logic [31:0] ALU_SUB_X = 32'h002;

   logic i_clk;
   logic i_rst_n;
   int   checkCount;
   int   errorCount;

   pipeline_ctrl_unit_if bus ();

   pipeline_ctrl_unit dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .io_bus  (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one decode-stage cycle just after the edge, then return at the sampling negedge.
   task automatic applyStimulus(input logic [31:0] instr, input logic [4:0] rwEx,
                                input logic [4:0] rwMem, input logic [4:0] rwW,
                                input logic ovf, input logic intr);
      @(posedge i_clk);
      #1;
      bus.i_instruction = instr;
      bus.i_rw_d        = instr[15:11];
      bus.i_rw_ex       = rwEx;
      bus.i_rw_mem      = rwMem;
      bus.i_rw_w        = rwW;
      bus.i_overflow    = ovf;
      bus.i_interrupt   = intr;
      @(negedge i_clk);
   endtask

   task automatic drain;
      repeat (3) applyStimulus(I_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      checkCount        = 0;
      errorCount        = 0;
      i_rst_n           = 1'b0;
      bus.i_instruction = I_NOP;
      bus.i_rw_d        = 5'd0;
      bus.i_rw_ex       = 5'd0;
      bus.i_rw_mem      = 5'd0;
      bus.i_rw_w        = 5'd0;
      bus.i_overflow    = 1'b0;
      bus.i_interrupt   = 1'b0;

      #12;
      checkOutput("rst RegWr",    {31'd0, bus.o_RegWr}, 32'd0);
      checkOutput("rst MemRead",  {31'd0, bus.o_MemRead}, 32'd0);
      checkOutput("rst MemWrite", {31'd0, bus.o_MemWrite}, 32'd0);
      checkOutput("rst MemtoReg", {31'd0, bus.o_MemtoReg}, 32'd0);
      checkOutput("rst mc0",      {31'd0, bus.o_mc0}, 32'd0);
      checkOutput("rst c0we",     {31'd0, bus.o_coproc0_we}, 32'd0);
      checkOutput("rst invalid",  {31'd0, bus.o_coproc0_invalid_instr}, 32'd0);
      checkOutput("rst stall",    {31'd0, bus.o_stall}, 32'd0);
      checkOutput("rst ASrc",     {30'd0, bus.o_ASrc}, 32'd0);
      checkOutput("rst BSrc",     {30'd0, bus.o_BSrc}, 32'd0);
      checkOutput("rst ALUCtrl",  {21'd0, bus.o_ALUCtrl}, 32'd0);
      checkOutput("nop RegDst",   {31'd0, bus.o_RegDst}, 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Writes to $0 are never forwarded or stalled on.
      applyStimulus(I_ADD_0_11, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("add RegDst", {31'd0, bus.o_RegDst}, 32'd1);
      checkOutput("add ALUSrc", {31'd0, bus.o_ALUSrc}, 32'd0);
      applyStimulus(I_OR_7_00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("r0 ASrc",    {30'd0, bus.o_ASrc}, 32'd0);
      checkOutput("r0 BSrc",    {30'd0, bus.o_BSrc}, 32'd0);
      checkOutput("r0 stall",   {31'd0, bus.o_stall}, 32'd0);
      checkOutput("r0 ALUCtrl", {21'd0, bus.o_ALUCtrl}, ALU_ADD_X);
      drain();

      // Dependent ALU chain.
      applyStimulus(I_ADD_3_12, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("chain1 stall", {31'd0, bus.o_stall}, 32'd0);
`ifdef PIPELINE_FORWARDING_EN
      applyStimulus(I_SUB_4_31, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("chain2 ASrc",  {30'd0, bus.o_ASrc}, 32'd1);
      checkOutput("chain2 BSrc",  {30'd0, bus.o_BSrc}, 32'd0);
      checkOutput("chain2 stall", {31'd0, bus.o_stall}, 32'd0);
      applyStimulus(I_AND_5_33, 5'd4, 5'd3, 5'd0, 1'b0, 1'b0);
      checkOutput("chain3 ASrc",    {30'd0, bus.o_ASrc}, 32'd2);
      checkOutput("chain3 BSrc",    {30'd0, bus.o_BSrc}, 32'd2);
      checkOutput("chain3 ALUCtrl", {21'd0, bus.o_ALUCtrl}, ALU_SUB_X);
      applyStimulus(I_OR_7_34, 5'd5, 5'd4, 5'd3, 1'b0, 1'b0);
      checkOutput("chain4 ASrc",  {30'd0, bus.o_ASrc}, 32'd3);
      checkOutput("chain4 BSrc",  {30'd0, bus.o_BSrc}, 32'd2);
      checkOutput("chain4 RegWr", {31'd0, bus.o_RegWr}, 32'd1);
`else
      applyStimulus(I_SUB_4_31, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("chain2 stall", {31'd0, bus.o_stall}, 32'd1);
      checkOutput("chain2 ASrc",  {30'd0, bus.o_ASrc}, 32'd0);
      applyStimulus(I_SUB_4_31, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
      checkOutput("chain3 stall",   {31'd0, bus.o_stall}, 32'd1);
      checkOutput("chain3 ALUCtrl", {21'd0, bus.o_ALUCtrl}, 32'd0);
      applyStimulus(I_SUB_4_31, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
      checkOutput("chain4 stall", {31'd0, bus.o_stall}, 32'd1);
      checkOutput("chain4 RegWr", {31'd0, bus.o_RegWr}, 32'd1);
      applyStimulus(I_SUB_4_31, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("chain5 stall", {31'd0, bus.o_stall}, 32'd0);
      applyStimulus(I_NOP, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("chain6 ALUCtrl", {21'd0, bus.o_ALUCtrl}, ALU_SUB_X);
`endif
      drain();

      // Load followed by a consumer of the loaded register.
      applyStimulus(I_LW_5, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("lw ALUSrc", {31'd0, bus.o_ALUSrc}, 32'd1);
      checkOutput("lw ExtOp",  {31'd0, bus.o_ExtOp}, 32'd1);
      checkOutput("lw stall",  {31'd0, bus.o_stall}, 32'd0);
      applyStimulus(I_ADD_6_55, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("ld-use stall", {31'd0, bus.o_stall}, 32'd1);
`ifdef PIPELINE_FORWARDING_EN
      applyStimulus(I_ADD_6_55, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
      checkOutput("ld-use2 stall",   {31'd0, bus.o_stall}, 32'd0);
      checkOutput("ld-use2 ASrc",    {30'd0, bus.o_ASrc}, 32'd2);
      checkOutput("ld-use2 BSrc",    {30'd0, bus.o_BSrc}, 32'd2);
      checkOutput("ld-use2 ALUCtrl", {21'd0, bus.o_ALUCtrl}, 32'd0);
      checkOutput("ld-use2 MemRead", {31'd0, bus.o_MemRead}, 32'd1);
      applyStimulus(I_NOP, 5'd6, 5'd0, 5'd5, 1'b0, 1'b0);
      checkOutput("ld-use3 ALUCtrl", {21'd0, bus.o_ALUCtrl}, ALU_ADD_X);
`else
      applyStimulus(I_ADD_6_55, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
      checkOutput("ld-use2 stall",   {31'd0, bus.o_stall}, 32'd1);
      checkOutput("ld-use2 BSrc",    {30'd0, bus.o_BSrc}, 32'd0);
      checkOutput("ld-use2 MemRead", {31'd0, bus.o_MemRead}, 32'd1);
      applyStimulus(I_ADD_6_55, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
      checkOutput("ld-use3 stall", {31'd0, bus.o_stall}, 32'd1);
      applyStimulus(I_ADD_6_55, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("ld-use4 stall", {31'd0, bus.o_stall}, 32'd0);
`endif
      drain();

      // Unsquashed add retires, then the same add with overflow must not write back.
      applyStimulus(I_ADD_3_12, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(I_NOP, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(I_NOP, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
      applyStimulus(I_NOP, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
      checkOutput("add retire RegWr", {31'd0, bus.o_RegWr}, 32'd1);
      applyStimulus(I_ADD_3_12, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(I_NOP, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0);
      checkOutput("ovf ALUCtrl", {21'd0, bus.o_ALUCtrl}, ALU_ADD_X);
      applyStimulus(I_NOP, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
      applyStimulus(I_NOP, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
      checkOutput("ovf squash RegWr", {31'd0, bus.o_RegWr}, 32'd0);

      // Interrupt in decode turns the decode instruction into an EX bubble.
      applyStimulus(I_ADD_3_12, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      applyStimulus(I_NOP, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("intr ALUCtrl", {21'd0, bus.o_ALUCtrl}, 32'd0);
      applyStimulus(I_NOP, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
      applyStimulus(I_NOP, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
      checkOutput("intr RegWr", {31'd0, bus.o_RegWr}, 32'd0);

      // Invalid opcode followed by mfc0.
      applyStimulus(I_BAD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(I_MFC0_8, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("bad invalid", {31'd0, bus.o_coproc0_invalid_instr}, 32'd1);
      checkOutput("mfc0 RegDst", {31'd0, bus.o_RegDst}, 32'd0);
      applyStimulus(I_NOP, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("mfc0 mc0",       {31'd0, bus.o_mc0}, 32'd1);
      checkOutput("mfc0 invalid",   {31'd0, bus.o_coproc0_invalid_instr}, 32'd0);
      checkOutput("bad MemWrite",   {31'd0, bus.o_MemWrite}, 32'd0);
      applyStimulus(I_NOP, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0);
      checkOutput("bad RegWr",      {31'd0, bus.o_RegWr}, 32'd0);
      applyStimulus(I_NOP, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0);
      checkOutput("mfc0 WB RegWr",  {31'd0, bus.o_RegWr}, 32'd1);

      // mtc0 then eret.
      applyStimulus(I_MTC0_9, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("mtc0 ALUSrc", {31'd0, bus.o_ALUSrc}, 32'd0);
      applyStimulus(I_ERET, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("mtc0 c0we", {31'd0, bus.o_coproc0_we}, 32'd1);
      checkOutput("eret flag", {31'd0, bus.o_eret}, 32'd1);
      applyStimulus(I_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checkOutput("eret c0we", {31'd0, bus.o_coproc0_we}, 32'd0);
      drain();

      // Asynchronous reset with a load in MEM and an add in WB.
      applyStimulus(I_ADD_3_12, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(I_LW_5, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(I_NOP, 5'd5, 5'd3, 5'd0, 1'b0, 1'b0);
      applyStimulus(I_ADD_6_55, 5'd0, 5'd5, 5'd3, 1'b0, 1'b0);
      checkOutput("pre-rst MemRead", {31'd0, bus.o_MemRead}, 32'd1);
      checkOutput("pre-rst RegWr",   {31'd0, bus.o_RegWr}, 32'd1);
      #2;
      i_rst_n = 1'b0;
      #1;
      checkOutput("mid-rst MemRead", {31'd0, bus.o_MemRead}, 32'd0);
      checkOutput("mid-rst RegWr",   {31'd0, bus.o_RegWr}, 32'd0);
      checkOutput("mid-rst ASrc",    {30'd0, bus.o_ASrc}, 32'd0);
      checkOutput("mid-rst stall",   {31'd0, bus.o_stall}, 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
